turn_controller: RTL and testbench

Sequences one player turn of the 6x6 memory-match game: accepts two card selections from the arrow-key cursor, fetches each card face from the card memory, and holds both cards revealed for a fixed display time. It then resolves the pair as matched or missed and tracks moves, pairs and game-over. It sits between the `synch`/`arrowKeys` front end and the `draw`/`ssegment` back end, and it replaces the ad-hoc compare-and-GO path as the single owner of game progress.

---
 rtl/match_pkg.sv | 23 ++
 rtl/show_timer.sv | 33 +++
 rtl/turn_controller.sv | 190 +++++++++++++++++++
 tb/tb_turn_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg: shared definitions for the memory-match game blocks
// (turn_controller, draw, arrowKeys).
//   state_e        - turn FSM state encoding (3 bits)
//   CARD_W / IDX_W - card face value width / board index width
//   DEF_NUM_CARDS  - default board size (6x6)
package match_pkg;

    localparam int CARD_W        = 5;
    localparam int IDX_W         = 6;
    localparam int DEF_NUM_CARDS = 36;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PICK1   = 3'd1,
        S_FETCH1  = 3'd2,
        S_PICK2   = 3'd3,
        S_FETCH2  = 3'd4,
        S_SHOW    = 3'd5,
        S_RESOLVE = 3'd6,
        S_DONE    = 3'd7
    } state_e;

endpackage

// File: rtl/show_timer.sv
// show_timer: loadable down-counter that times how long both cards stay
// revealed.
//   i_clock  - system clock
//   i_reset  - synchronous active-high reset
//   i_load   - load i_value into the counter
//   i_value  - count to load
//   o_done   - high on the last counting cycle (count == 1), so the owner
//              leaves its wait state exactly i_value cycles after the load
module show_timer #(
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int W           = $clog2(SHOW_CYCLES + 1)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign o_done = (r_count == W'(1));

endmodule

// File: rtl/turn_controller.sv
// turn_controller: sequences one player turn of the memory-match game and
// owns all game progress (matched mask, moves, pairs, game over).
//   i_clock, i_reset          - clock, synchronous active-high reset
//   i_start                   - start/restart pulse (honoured in IDLE/DONE)
//   i_select, i_cursor        - pick the card under the cursor
//   o_mem_addr, i_mem_data    - card memory read port (1-cycle latency)
//   o_card1/2_idx, _val       - the two picks and their captured faces
//   o_reveal1/2               - card face currently shown
//   o_matched                 - per-card matched mask
//   o_moves, o_pairs          - completed turns (saturating), matched pairs
//   o_game_over, o_state      - all pairs found, current FSM state
module turn_controller
    import match_pkg::*;
#(
    parameter int NUM_CARDS   = DEF_NUM_CARDS,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_select,
    input  logic [IDX_W-1:0]     i_cursor,
    output logic [IDX_W-1:0]     o_mem_addr,
    input  logic [CARD_W-1:0]    i_mem_data,
    output logic [IDX_W-1:0]     o_card1_idx,
    output logic [IDX_W-1:0]     o_card2_idx,
    output logic [CARD_W-1:0]    o_card1_val,
    output logic [CARD_W-1:0]    o_card2_val,
    output logic                 o_reveal1,
    output logic                 o_reveal2,
    output logic [NUM_CARDS-1:0] o_matched,
    output logic [7:0]           o_moves,
    output logic [4:0]           o_pairs,
    output logic                 o_game_over,
    output logic [2:0]           o_state
);

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_PICK1   = S_PICK1;
    localparam logic [2:0] ST_FETCH1  = S_FETCH1;
    localparam logic [2:0] ST_PICK2   = S_PICK2;
    localparam logic [2:0] ST_FETCH2  = S_FETCH2;
    localparam logic [2:0] ST_SHOW    = S_SHOW;
    localparam logic [2:0] ST_RESOLVE = S_RESOLVE;
    localparam logic [2:0] ST_DONE    = S_DONE;
    localparam int         TMR_W      = $clog2(SHOW_CYCLES + 1);

    logic [2:0]           r_state;
    logic                 r_fetch_2nd;   // second cycle of a FETCH state
    logic [IDX_W-1:0]     r_mem_addr;
    logic [IDX_W-1:0]     r_card1_idx, r_card2_idx;
    logic [CARD_W-1:0]    r_card1_val, r_card2_val;
    logic                 r_reveal1, r_reveal2;
    logic [NUM_CARDS-1:0] r_matched;
    logic [7:0]           r_moves;
    logic [5:0]           r_pairs;       // one spare bit so a 64-card board can count 32
    logic                 r_game_over;

    logic [63:0]          w_matched_ext;
    logic                 w_pick_ok;
    logic                 w_is_pair;
    logic [5:0]           w_pairs_next;
    logic                 w_timer_load;
    logic                 w_timer_done;

    // Widen the mask so any 6-bit cursor can index it; cards beyond the
    // board are rejected by the range test anyway.
    assign w_matched_ext = 64'(r_matched);
    assign w_pick_ok     = i_select && ({1'b0, i_cursor} < 7'(NUM_CARDS))
                           && !w_matched_ext[i_cursor];
    assign w_is_pair     = (r_card1_val == r_card2_val);
    assign w_pairs_next  = r_pairs + 6'(w_is_pair);
    assign w_timer_load  = (r_state == ST_FETCH2) && r_fetch_2nd;

    show_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_show_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_timer_load),
        .i_value (TMR_W'(SHOW_CYCLES)),
        .o_done  (w_timer_done)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_fetch_2nd <= 1'b0;
            r_mem_addr  <= '0;
            r_card1_idx <= '0;
            r_card2_idx <= '0;
            r_card1_val <= '0;
            r_card2_val <= '0;
            r_reveal1   <= 1'b0;
            r_reveal2   <= 1'b0;
            r_matched   <= '0;
            r_moves     <= '0;
            r_pairs     <= '0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // start wins over a simultaneous select here
                    if (i_start) begin
                        r_mem_addr  <= '0;
                        r_card1_idx <= '0;
                        r_card2_idx <= '0;
                        r_card1_val <= '0;
                        r_card2_val <= '0;
                        r_reveal1   <= 1'b0;
                        r_reveal2   <= 1'b0;
                        r_matched   <= '0;
                        r_moves     <= '0;
                        r_pairs     <= '0;
                        r_game_over <= 1'b0;
                        r_state     <= ST_PICK1;
                    end
                end
                ST_PICK1: begin
                    if (w_pick_ok) begin
                        r_card1_idx <= i_cursor;
                        r_mem_addr  <= i_cursor;
                        r_fetch_2nd <= 1'b0;
                        r_state     <= ST_FETCH1;
                    end
                end
                ST_FETCH1: begin
                    // memory answers one edge after the address; capture on the next
                    r_fetch_2nd <= ~r_fetch_2nd;
                    if (r_fetch_2nd) begin
                        r_card1_val <= i_mem_data;
                        r_reveal1   <= 1'b1;
                        r_state     <= ST_PICK2;
                    end
                end
                ST_PICK2: begin
                    if (w_pick_ok && (i_cursor != r_card1_idx)) begin
                        r_card2_idx <= i_cursor;
                        r_mem_addr  <= i_cursor;
                        r_fetch_2nd <= 1'b0;
                        r_state     <= ST_FETCH2;
                    end
                end
                ST_FETCH2: begin
                    r_fetch_2nd <= ~r_fetch_2nd;
                    if (r_fetch_2nd) begin
                        r_card2_val <= i_mem_data;
                        r_reveal2   <= 1'b1;
                        r_state     <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_timer_done)
                        r_state <= ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    if (r_moves != 8'hFF)
                        r_moves <= r_moves + 8'd1;
                    if (w_is_pair) begin
                        for (int i = 0; i < NUM_CARDS; i++)
                            if ((IDX_W'(i) == r_card1_idx) || (IDX_W'(i) == r_card2_idx))
                                r_matched[i] <= 1'b1;
                        r_pairs <= w_pairs_next;
                    end
                    r_reveal1 <= 1'b0;
                    r_reveal2 <= 1'b0;
                    if (w_pairs_next == 6'(NUM_CARDS / 2)) begin
                        r_game_over <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_state <= ST_PICK1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_state     = r_state;
    assign o_mem_addr  = r_mem_addr;
    assign o_card1_idx = r_card1_idx;
    assign o_card2_idx = r_card2_idx;
    assign o_card1_val = r_card1_val;
    assign o_card2_val = r_card2_val;
    assign o_reveal1   = r_reveal1;
    assign o_reveal2   = r_reveal2;
    assign o_matched   = r_matched;
    assign o_moves     = r_moves;
    assign o_pairs     = r_pairs[4:0];
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: 36 cards, 4-cycle show time, card memory with
// one-cycle latency where face(i) = i/2. A score model (matched set, moves,
// pairs) is updated from the game rules after each turn.
module tb_turn_controller;

    localparam int N    = 36;
    localparam int SHOW = 4;

    logic         clk = 1'b0;
    logic         reset, start, select;
    logic [5:0]   cursor, mem_addr, card1_idx, card2_idx;
    logic [4:0]   mem_data, card1_val, card2_val, pairs;
    logic         reveal1, reveal2, game_over;
    logic [N-1:0] matched;
    logic [7:0]   moves;
    logic [2:0]   state;

    int total = 0;
    int bad   = 0;

    // score model
    logic [N-1:0] exp_matched;
    int           exp_moves, exp_pairs, exp_c1, exp_c2;

    turn_controller #(.NUM_CARDS(N), .SHOW_CYCLES(SHOW)) dut (
        .i_clock     (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_select    (select),
        .i_cursor    (cursor),
        .o_mem_addr  (mem_addr),
        .i_mem_data  (mem_data),
        .o_card1_idx (card1_idx),
        .o_card2_idx (card2_idx),
        .o_card1_val (card1_val),
        .o_card2_val (card2_val),
        .o_reveal1   (reveal1),
        .o_reveal2   (reveal2),
        .o_matched   (matched),
        .o_moves     (moves),
        .o_pairs     (pairs),
        .o_game_over (game_over),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    // card memory: registered read
    always @(posedge clk) mem_data <= 5'(mem_addr >> 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_matched = '0;
        exp_moves   = 0;
        exp_pairs   = 0;
        exp_c1      = 0;
        exp_c2      = 0;
    endtask

    task automatic pulse_select(input int c);
        select = 1'b1;
        cursor = 6'(c);
        tick();
        select = 1'b0;
    endtask

    task automatic first_pick(input int a);
        pulse_select(a);
        exp_c1 = a;
        total++; if (state !== 3'd2) begin bad++; $display("FAIL p1_state got=%0d exp=2", state); end
        total++; if (card1_idx !== 6'(a)) begin bad++; $display("FAIL p1_idx got=%0d exp=%0d", card1_idx, a); end
        total++; if (mem_addr !== 6'(a)) begin bad++; $display("FAIL p1_addr got=%0d exp=%0d", mem_addr, a); end
        tick();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL fetch1_len got=%0d exp=2", state); end
        tick();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL f1_state got=%0d exp=3", state); end
        total++; if (card1_val !== 5'(a / 2)) begin bad++; $display("FAIL c1_val got=%0d exp=%0d", card1_val, a / 2); end
        total++; if ({reveal1, reveal2} !== 2'b10) begin bad++; $display("FAIL rev_after_f1 got=%b exp=10", {reveal1, reveal2}); end
    endtask

    // second pick, show period (optionally with select/start noise), resolve
    task automatic second_pick(input int a, input int b, input bit noisy);
        bit last;
        pulse_select(b);
        exp_c2 = b;
        total++; if (state !== 3'd4) begin bad++; $display("FAIL p2_state got=%0d exp=4", state); end
        total++; if (card2_idx !== 6'(b)) begin bad++; $display("FAIL p2_idx got=%0d exp=%0d", card2_idx, b); end
        tick();
        tick();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL f2_state got=%0d exp=5", state); end
        total++; if (card2_val !== 5'(b / 2)) begin bad++; $display("FAIL c2_val got=%0d exp=%0d", card2_val, b / 2); end
        total++; if ({reveal1, reveal2} !== 2'b11) begin bad++; $display("FAIL rev_show got=%b exp=11", {reveal1, reveal2}); end
        for (int k = 0; k < SHOW; k++) begin
            if (noisy) begin
                select = 1'($urandom);
                start  = 1'($urandom);
                cursor = 6'($urandom_range(0, N - 1));
            end
            tick();
            select = 1'b0;
            start  = 1'b0;
            total++; if (state !== ((k < SHOW - 1) ? 3'd5 : 3'd6)) begin bad++; $display("FAIL show_len k=%0d got=%0d", k, state); end
            total++; if (card2_idx !== 6'(b)) begin bad++; $display("FAIL show_idx got=%0d exp=%0d", card2_idx, b); end
        end
        // resolve by the game rules
        if (exp_moves < 255) exp_moves++;
        if (a / 2 == b / 2) begin
            exp_matched[a] = 1'b1;
            exp_matched[b] = 1'b1;
            exp_pairs++;
        end
        tick();
        total++; if (state !== ((exp_pairs == N / 2) ? 3'd7 : 3'd1)) begin bad++; $display("FAIL res_state got=%0d pairs=%0d", state, exp_pairs); end
        total++; if (moves !== 8'(exp_moves)) begin bad++; $display("FAIL moves got=%0d exp=%0d", moves, exp_moves); end
        total++; if (pairs !== 5'(exp_pairs)) begin bad++; $display("FAIL pairs got=%0d exp=%0d", pairs, exp_pairs); end
        total++; if (matched !== exp_matched) begin bad++; $display("FAIL matched got=%h exp=%h", matched, exp_matched); end
        total++; if ({reveal1, reveal2} !== 2'b00) begin bad++; $display("FAIL rev_clear got=%b exp=00", {reveal1, reveal2}); end
        last = (exp_pairs == N / 2);
        total++; if (game_over !== last) begin bad++; $display("FAIL game_over got=%b exp=%b", game_over, last); end
    endtask

    task automatic play_turn(input int a, input int b, input bit noisy);
        first_pick(a);
        second_pick(a, b, noisy);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; select = 1'b0; cursor = '0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++; if ({mem_addr, card1_idx, card2_idx, card1_val, card2_val} !== 28'd0) begin bad++; $display("FAIL rst_regs got=%h exp=0", {mem_addr, card1_idx, card2_idx, card1_val, card2_val}); end
        total++; if ({reveal1, reveal2, game_over, moves, pairs} !== 16'd0) begin bad++; $display("FAIL rst_score got=%h exp=0", {reveal1, reveal2, game_over, moves, pairs}); end
        total++; if (matched !== '0) begin bad++; $display("FAIL rst_matched got=%h exp=0", matched); end
    endtask

    task automatic test_idle_ignore();
        pulse_select(3);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_select got=%0d exp=0", state); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", state); end
        pulse_select(0);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL pre_rst got=%0d exp=2", state); end
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL mid_rst got=%0d exp=0", state); end
        total++; if (card1_idx !== 6'd0 || mem_addr !== 6'd0) begin bad++; $display("FAIL mid_rst_regs got=%0d/%0d exp=0/0", card1_idx, mem_addr); end
        start = 1'b1; tick(); start = 1'b0;
        model_clear();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL restart_state got=%0d exp=1", state); end
        total++; if (moves !== 8'd0) begin bad++; $display("FAIL restart_moves got=%0d exp=0", moves); end
        total++; if (reveal1 !== 1'b0) begin bad++; $display("FAIL restart_rev got=%b exp=0", reveal1); end
    endtask

    task automatic test_match();
        play_turn(0, 1, 1'b0);
    endtask

    task automatic test_mismatch();
        play_turn(2, 5, 1'b0);
    endtask

    task automatic test_reject();
        int rej1[2] = '{40, 0};
        int rej2[3] = '{4, 1, 63};
        foreach (rej1[i]) begin
            pulse_select(rej1[i]);
            total++; if (state !== 3'd1) begin bad++; $display("FAIL rej1_state c=%0d got=%0d exp=1", rej1[i], state); end
            total++; if (card1_idx !== 6'(exp_c1) || mem_addr !== 6'(exp_c2)) begin bad++; $display("FAIL rej1_regs got=%0d/%0d exp=%0d/%0d", card1_idx, mem_addr, exp_c1, exp_c2); end
        end
        first_pick(4);
        foreach (rej2[i]) begin
            pulse_select(rej2[i]);
            total++; if (state !== 3'd3) begin bad++; $display("FAIL rej2_state c=%0d got=%0d exp=3", rej2[i], state); end
            total++; if (card2_idx !== 6'(exp_c2) || mem_addr !== 6'(exp_c1)) begin bad++; $display("FAIL rej2_regs got=%0d/%0d exp=%0d/%0d", card2_idx, mem_addr, exp_c2, exp_c1); end
        end
        second_pick(4, 3, 1'b0);
    endtask

    task automatic test_show_noise();
        play_turn(6, 7, 1'b1);
    endtask

    task automatic test_full_game();
        int p, q, r;
        while (exp_pairs < N / 2) begin
            r = $urandom_range(0, N / 2 - 1);
            p = -1;
            for (int k = 0; k < N / 2; k++)
                if (p < 0 && !exp_matched[2 * ((r + k) % (N / 2))]) p = (r + k) % (N / 2);
            if (exp_pairs < N / 2 - 1 && $urandom_range(0, 2) == 0) begin
                q = -1;
                for (int k = 1; k < N / 2; k++)
                    if (q < 0 && !exp_matched[2 * ((p + k) % (N / 2))]) q = (p + k) % (N / 2);
                play_turn(2 * p, 2 * q + 1, 1'($urandom));
            end
            if ($urandom_range(0, 1) == 0) play_turn(2 * p, 2 * p + 1, 1'($urandom));
            else                           play_turn(2 * p + 1, 2 * p, 1'($urandom));
        end
    endtask

    task automatic test_restart();
        pulse_select(8);
        total++; if (state !== 3'd7 || game_over !== 1'b1) begin bad++; $display("FAIL done_hold got=%0d/%b exp=7/1", state, game_over); end
        start = 1'b1; select = 1'b1; cursor = 6'd9;
        tick();
        start = 1'b0; select = 1'b0;
        model_clear();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rs_state got=%0d exp=1", state); end
        total++; if (matched !== '0 || pairs !== 5'd0 || moves !== 8'd0) begin bad++; $display("FAIL rs_score got=%h/%0d/%0d exp=0/0/0", matched, pairs, moves); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rs_go got=%b exp=0", game_over); end
        total++; if (card1_idx !== 6'd0 || card1_val !== 5'd0) begin bad++; $display("FAIL rs_card got=%0d/%0d exp=0/0", card1_idx, card1_val); end
    endtask

    task automatic test_moves_saturate();
        for (int t = 0; t < 260; t++) begin
            if ($urandom_range(0, 1) == 0) play_turn(2 * $urandom_range(0, 8), 2 * $urandom_range(9, 17) + 1, 1'($urandom));
            else                           play_turn(2 * $urandom_range(9, 17), 2 * $urandom_range(0, 8) + 1, 1'($urandom));
        end
        total++; if (moves !== 8'd255) begin bad++; $display("FAIL moves_sat got=%0d exp=255", moves); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_reset_mid();
        test_match();
        test_mismatch();
        test_reject();
        test_show_noise();
        test_full_game();
        test_restart();
        test_moves_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
